// File: rtl/ef_gpio8_apb_arbiter.sv
// Two-requester round-robin arbiter and APB master sequencer for the EF_GPIO8 APB slave port.
// Optional ACCESS-phase timeout abort is enabled by defining EF_GPIO8_ARB_TIMEOUT_EN.
module ef_gpio8_apb_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    output logic              r0_done,
    output logic [31:0]       r0_rdata,
    output logic              r0_err,
    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    output logic              r1_done,
    output logic [31:0]       r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [31:0]       r_pwdata;

    logic w_any_valid;
    logic w_winner;
    logic w_ready_done;
    logic w_timeout;
    logic w_complete;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("ef_gpio8_apb_arbiter: TIMEOUT_CYCLES must lie in 1..65535");
    end

    // Under contention the requester that did not win last time goes next.
    assign w_any_valid = r0_valid | r1_valid;
    assign w_winner    = (r0_valid && r1_valid) ? ~r_last_grant : r1_valid;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= S_IDLE;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_grant  <= w_winner;
                        r_pwrite <= w_winner ? r1_write : r0_write;
                        r_paddr  <= w_winner ? r1_addr  : r0_addr;
                        r_pwdata <= w_winner ? r1_wdata : r0_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_complete) begin
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef EF_GPIO8_ARB_TIMEOUT_EN
    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_wait_cnt;

    // Counts ACCESS cycles already spent with PREADY low; zero in the first ACCESS cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !PREADY) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == S_ACCESS) && !PREADY && (r_wait_cnt == LP_TIMEOUT);
`else
    assign w_timeout = 1'b0;
`endif

    // A ready slave takes priority over an abort landing in the same cycle.
    assign w_ready_done = (r_state == S_ACCESS) && PREADY;
    assign w_complete   = w_ready_done || w_timeout;

    assign r0_done  = w_complete && !r_grant;
    assign r1_done  = w_complete &&  r_grant;
    assign r0_err   = w_timeout  && !r_grant;
    assign r1_err   = w_timeout  &&  r_grant;
    assign r0_rdata = (w_ready_done && !r_grant) ? PRDATA : 32'd0;
    assign r1_rdata = (w_ready_done &&  r_grant) ? PRDATA : 32'd0;

    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;

endmodule

// File: doc/ef_gpio8_apb_arbiter.md
Name: ef_gpio8_apb_arbiter

Overview:
- Two-requester round-robin arbiter and APB master sequencer that shares the single APB slave port of the EF_GPIO8 APB wrapper.
- Typical requesters are a CPU bridge and an autonomous pattern engine.
- Each requester issues one 32-bit read or write at a time over a valid/done handshake.
- The block serialises requests into legal APB SETUP/ACCESS phases and returns read data and completion status.

Parameters:
- ADDR_W, 16, APB address width; r0_addr, r1_addr and PADDR are all this width.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles with PREADY low before abort. Used only with the optional feature. Range 1..65535.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- r0_valid  in  1  requester 0 transfer request; held until r0_done.
- r0_write  in  1  requester 0 direction; 1 = write.
- r0_addr  in  ADDR_W  requester 0 address.
- r0_wdata  in  32  requester 0 write data.
- r0_done  out  1  one-cycle completion strobe for requester 0.
- r0_rdata  out  32  requester 0 read data; valid while r0_done.
- r0_err  out  1  requester 0 error flag; valid while r0_done.
- r1_valid, r1_write, r1_addr, r1_wdata, r1_done, r1_rdata, r1_err: identical set for requester 1.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- IDLE: on a PCLK edge with any rN_valid=1, select a winner, latch its write/addr/wdata into registers that drive PWRITE/PADDR/PWDATA, record grant=N, and go to SETUP.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first contention.
- SETUP always advances to ACCESS after exactly one cycle.
- ACCESS:
  - Stays while PREADY=0.
  - In the cycle PREADY=1: rN_done=1 for the granted N only (combinational), rN_rdata=PRDATA (combinational), rN_err=0.
  - On that edge: last_grant<=grant, go to IDLE.
- Non-granted requester's done/err are 0 and its rdata is 0.
- Latency with PREADY tied 1: valid sampled at edge k; SETUP in cycle k..k+1; ACCESS plus done in the next cycle. Done therefore appears 2 cycles after the sampling edge.
- Throughput: minimum 3 cycles per transfer, including one mandatory IDLE cycle between transfers; no back-to-back SETUP.
- Requester rules:
  - Requester drops rN_valid on the edge where done is sampled, or raises it again for the next request.
  - Deassertion of rN_valid during SETUP/ACCESS is ignored; the transfer completes and done still pulses.
  - Request fields are latched at grant; later changes have no effect on the current transfer.
- PWDATA/PADDR/PWRITE hold their last values in IDLE; PWDATA is driven on reads as well.
- Reset values: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, last_grant=1, all done/err=0, all rdata=0.
- Reset asserted mid-transfer: PSEL/PENABLE drop to 0 immediately (asynchronous), no done is issued, and the in-flight transfer is lost.

Optional Feature:
- Macro: EF_GPIO8_ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES while PREADY=0, in that cycle: granted rN_done=1, rN_err=1, rN_rdata=0.
  - FSM returns to IDLE and last_grant updates as for normal completion.
  - If PREADY=1 in the same cycle the counter hits the limit, normal completion wins (err=0).
- Disabled: no counter is instantiated, ACCESS waits indefinitely for PREADY, and r0_err/r1_err are constant 0.

Test Plan:
- r0 write addr=0x0004, wdata=0x000000A5, PREADY=1 -> PSEL 2 cycles, PENABLE 1 cycle, PWRITE=1, PADDR=0x0004, PWDATA=0xA5; r0_done pulses 2 cycles after valid sampled, r0_err=0.
- r1 read addr=0x0000, slave returns PRDATA=0x0000003C with 3 wait states -> ACCESS lasts 4 cycles; r1_done=1 and r1_rdata=0x3C in the final cycle only; r0_done stays 0.
- r0 and r1 both valid from reset, each issuing 4 writes -> grant order r0,r1,r0,r1,r0,r1,r0,r1; IDLE cycle between each transfer.
- r0 drops valid during SETUP -> transfer still completes with r0_done=1; no second transfer starts.
- PRESETn pulsed low during ACCESS with PREADY=0 -> PSEL=PENABLE=0 immediately; after release, first contention grants r0.
- With EF_GPIO8_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, PREADY held 0 -> r0_done=1, r0_err=1, r0_rdata=0 after 8 ACCESS cycles, then IDLE. Without the macro: no done after 100 cycles.
